uart_loader: RTL

//  Boot-time program loader upstream of the CPU/memory pair in tangle_soc.

---
 rtl/uart_loader_pkg.sv | 30 +++
 rtl/uart_rx.sv | 126 ++++++++++++
 rtl/uart_loader.sv | 108 ++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types for the UART boot loader.
//   - rx_state_t : receive FSM states of uart_rx
//   - ld_state_t : image loader FSM states of uart_loader
//   - make_word  : assembles a little-endian 16-bit word from two bytes
package uart_loader_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 104;  // 12 MHz / 115200

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [2:0] {
    LD_LEN_LO,
    LD_LEN_HI,
    LD_DAT_LO,
    LD_DAT_HI,
    LD_WRITE,
    LD_DONE
  } ld_state_t;

  function automatic logic [15:0] make_word(input logic [7:0] lo, input logic [7:0] hi);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer.
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a low level
//   RX_START | half a bit into the start bit, then recheck (glitch filter)
//   RX_DATA  | sampling 8 data bits, LSB first, one per bit time
//   RX_STOP  | sampling the stop bit
//   RX_BREAK | stop bit was low; wait for the line to return high
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   rx_i           raw serial input (async to clk_i)
//   byte_o         last good byte (held)
//   byte_valid_o   one-cycle pulse when byte_o is updated
//   frame_err_o    sticky, set when a stop bit is sampled low
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t        state, state_next;
  logic             rx_meta, rx_sync;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_q;
  logic             tick;
  logic             load_half, load_bit, shift_en, emit, set_err;

  assign tick = (baud_cnt == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= RX_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_half  = 1'b0;
    load_bit   = 1'b0;
    shift_en   = 1'b0;
    emit       = 1'b0;
    set_err    = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rx_sync) begin
          state_next = RX_START;
          load_half  = 1'b1;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_sync) begin
            state_next = RX_IDLE;
          end else begin
            state_next = RX_DATA;
            load_bit   = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          load_bit = 1'b1;
          if (bit_cnt == 3'd7) state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rx_sync) begin
            emit       = 1'b1;
            state_next = RX_IDLE;
          end else begin
            set_err    = 1'b1;
            state_next = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        if (rx_sync) state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift_q      <= '0;
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      byte_valid_o <= emit;
      if (load_half)          baud_cnt <= HALF_LOAD;
      else if (load_bit)      baud_cnt <= BIT_LOAD;
      else if (baud_cnt != '0) baud_cnt <= baud_cnt - 1'b1;
      if (state == RX_START)  bit_cnt <= '0;
      else if (shift_en)      bit_cnt <= bit_cnt + 1'b1;
      if (shift_en)           shift_q <= {rx_sync, shift_q[7:1]};
      if (emit)               byte_o <= shift_q;
      if (set_err)            frame_err_o <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Boot-time program loader: receives a length-prefixed little-endian word
// image over UART and writes it to memory, holding the CPU in reset until
// the image is complete.
//   state     | meaning
//   LD_LEN_LO | waiting for the low byte of the word count N
//   LD_LEN_HI | waiting for the high byte of N
//   LD_DAT_LO | waiting for the low byte of the next word
//   LD_DAT_HI | waiting for the high byte of the next word
//   LD_WRITE  | one-cycle memory write strobe
//   LD_DONE   | image loaded, CPU released, further bytes ignored
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   uart_rx_i      serial input, idle high
//   mem_addr_o     word address of the current write
//   mem_data_o     word to write
//   mem_we_o       write strobe, one cycle per word
//   cpu_rst_o      1 holds the CPU in reset until the image is loaded
//   frame_err_o    sticky framing error from the receiver
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  uart_rx_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [15:0]           mem_data_o,
  output logic                  mem_we_o,
  output logic                  cpu_rst_o,
  output logic                  frame_err_o
);

  logic [7:0]            rx_byte;
  logic                  rx_valid;
  ld_state_t             state, state_next;
  logic [15:0]           len_q;
  logic [7:0]            lo_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [15:0]           count_q;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_i        (uart_rx_i),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (frame_err_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= LD_LEN_LO;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_we_o   = 1'b0;
    cpu_rst_o  = 1'b1;
    case (state)
      LD_LEN_LO: if (rx_valid) state_next = LD_LEN_HI;
      LD_LEN_HI: begin
        if (rx_valid) state_next = ({rx_byte, len_q[7:0]} == 16'd0) ? LD_DONE : LD_DAT_LO;
      end
      LD_DAT_LO: if (rx_valid) state_next = LD_DAT_HI;
      LD_DAT_HI: if (rx_valid) state_next = LD_WRITE;
      LD_WRITE: begin
        mem_we_o   = 1'b1;
        // count_q still holds the number of words written before this one
        state_next = (count_q + 16'd1 == len_q) ? LD_DONE : LD_DAT_LO;
      end
      LD_DONE:  cpu_rst_o = 1'b0;
      default:  state_next = LD_LEN_LO;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q      <= '0;
      lo_q       <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      case (state)
        LD_LEN_LO: if (rx_valid) len_q[7:0]  <= rx_byte;
        LD_LEN_HI: if (rx_valid) len_q[15:8] <= rx_byte;
        LD_DAT_LO: if (rx_valid) lo_q        <= rx_byte;
        LD_DAT_HI: begin
          if (rx_valid) begin
            mem_data_o <= make_word(lo_q, rx_byte);
            mem_addr_o <= idx_q;
          end
        end
        LD_WRITE: begin
          idx_q   <= idx_q + 1'b1;
          count_q <= count_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
